id_ex_stage_reg: RTL and testbench
==================================

ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 SHALL have: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have: valid_id  in  1  ID holds a real instruction.
REQ-004 SHALL have: src_zero_addr_id, src_one_addr_id, dst_id  in  5 each  ID register addresses.
REQ-005 SHALL have: use_src_zero_id, use_src_one_id  in  1 each  ID instruction reads that source.
REQ-006 SHALL have: src_zero_id, src_one_id, imm_id, pc_id  in  32 each  ID operands, immediate, PC.
REQ-007 SHALL have: ctrl_id  in  ctrl_t (9)  {alu_op[3:0], regwrite, memread, memwrite, memtoreg, alusrc}.
REQ-008 SHALL have: flush_ex  in  1  taken branch in EX, kill ID instruction.
REQ-009 SHALL have: stall_ext  in  1  downstream memory wait, freeze stage.
REQ-010 SHALL have: valid_ex, ctrl_ex, dst_ex, src_zero_addr_ex, src_one_addr_ex, src_zero_ex, src_one_ex, imm_ex, pc_ex  out  widths as ID  registered EX fields feeding the forwarding mux.
REQ-011 SHALL have: stall_if_id  out  1  hold PC and IF/ID register.
REQ-012 SHALL have: bubble_cnt, flush_cnt  out  16 each  saturating event counters.

Function
REQ-013 SHALL compute load_use = valid_ex & ctrl_ex.memread & (dst_ex!=0) & valid_id & ((use_src_zero_id & src_zero_addr_id==dst_ex) | (use_src_one_id & src_one_addr_id==dst_ex)).
REQ-014 SHALL drive stall_if_id = stall_ext | (load_use & ~flush_ex), combinationally.
REQ-015 SHALL apply per-edge priority: stall_ext > flush_ex > load_use > normal advance.
REQ-016 stall_ext=1: all registered outputs and counters hold.
REQ-017 flush_ex=1 (no stall_ext): next valid_ex=0, ctrl_ex=0 (all control bits clear); flush_cnt +1.
REQ-018 load_use=1 (no stall_ext, no flush): bubble inserted, valid_ex=0, ctrl_ex=0; bubble_cnt +1.
REQ-019 Normal advance: every EX field captures its ID counterpart; valid_ex=valid_id; ctrl_ex=valid_id ? ctrl_id : 0.
REQ-020 Bubble/flush SHALL leave data fields (operands, addresses, imm, pc) don't-care but SHALL zero dst_ex.
REQ-021 Load-use stall SHALL last exactly one cycle per load, since the bubble clears the EX memread.
REQ-022 Back-to-back dependent loads SHALL each stall once; no duplicated or lost instruction.
REQ-023 Counters SHALL saturate at 16'hFFFF, never wrap.
REQ-024 Register 0 SHALL never cause a stall, regardless of memread.
REQ-025 Latency ID->EX SHALL be one cycle.

Reset
REQ-026 rst_n low SHALL asynchronously clear valid_ex, ctrl_ex, dst_ex, all data outputs, and both counters to 0.
REQ-027 stall_if_id SHALL be 0 while reset is asserted, with inputs idle.
REQ-028 Reset deassertion mid-stream SHALL resume with an empty (bubble) EX stage.

Structure
REQ-029 mips_pkg SHALL hold ctrl_t, ALU_OP_W=4, REG_ADDR_W=5, DATA_W=32, CNT_W=16.
REQ-030 Detection SHALL be in one combinational sub-module, load_use_detect; registers and counters stay in id_ex_stage_reg.

Verification
REQ-031 lw r5 in EX (memread=1, dst_ex=5), ID add uses src_zero=5 -> stall_if_id=1 one cycle, valid_ex=0 next, bubble_cnt=1, add enters EX the following cycle.
REQ-032 lw r0 in EX, ID uses r0 -> no stall, bubble_cnt=0.
REQ-033 load_use and flush_ex together -> stall_if_id=0, valid_ex=0, flush_cnt=1, bubble_cnt=0.
REQ-034 stall_ext=1 for 3 cycles during load_use -> outputs frozen; after release, one bubble, bubble_cnt=1.
REQ-035 Preload bubble_cnt to 16'hFFFE, force 3 load-use events -> bubble_cnt=16'hFFFF.
REQ-036 rst_n low mid-stall -> all outputs 0 immediately, no clock edge needed.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS ID/EX pipeline slice.
// ctrl_t packs the decoded control bits that travel with an instruction.
package mips_pkg;

  localparam int ALU_OP_W   = 4;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int CNT_W      = 16;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                regwrite;
    logic                memread;
    logic                memwrite;
    logic                memtoreg;
    logic                alusrc;
  } ctrl_t;

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by the
// instruction currently in ID. Register 0 is hard-wired and never hazards.
module load_use_detect
  import mips_pkg::*;
(
  input  logic                  valid_ex,
  input  logic                  memread_ex,
  input  logic [REG_ADDR_W-1:0] dst_ex,
  input  logic                  valid_id,
  input  logic                  use_src_zero_id,
  input  logic [REG_ADDR_W-1:0] src_zero_addr_id,
  input  logic                  use_src_one_id,
  input  logic [REG_ADDR_W-1:0] src_one_addr_id,
  output logic                  load_use
);

  logic hit_zero;
  logic hit_one;

  assign hit_zero = use_src_zero_id & (src_zero_addr_id == dst_ex);
  assign hit_one  = use_src_one_id  & (src_one_addr_id  == dst_ex);

  assign load_use = valid_ex & memread_ex & (dst_ex != '0) & valid_id
                  & (hit_zero | hit_one);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// external freeze, plus saturating bubble/flush event counters.
module id_ex_stage_reg
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_id,
  input  logic [REG_ADDR_W-1:0] src_zero_addr_id,
  input  logic [REG_ADDR_W-1:0] src_one_addr_id,
  input  logic [REG_ADDR_W-1:0] dst_id,
  input  logic                  use_src_zero_id,
  input  logic                  use_src_one_id,
  input  logic [DATA_W-1:0]     src_zero_id,
  input  logic [DATA_W-1:0]     src_one_id,
  input  logic [DATA_W-1:0]     imm_id,
  input  logic [DATA_W-1:0]     pc_id,
  input  ctrl_t                 ctrl_id,
  input  logic                  flush_ex,
  input  logic                  stall_ext,
  output logic                  valid_ex,
  output ctrl_t                 ctrl_ex,
  output logic [REG_ADDR_W-1:0] dst_ex,
  output logic [REG_ADDR_W-1:0] src_zero_addr_ex,
  output logic [REG_ADDR_W-1:0] src_one_addr_ex,
  output logic [DATA_W-1:0]     src_zero_ex,
  output logic [DATA_W-1:0]     src_one_ex,
  output logic [DATA_W-1:0]     imm_ex,
  output logic [DATA_W-1:0]     pc_ex,
  output logic                  stall_if_id,
  output logic [CNT_W-1:0]      bubble_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  logic load_use;

  load_use_detect u_detect (
    .valid_ex         (valid_ex),
    .memread_ex       (ctrl_ex.memread),
    .dst_ex           (dst_ex),
    .valid_id         (valid_id),
    .use_src_zero_id  (use_src_zero_id),
    .src_zero_addr_id (src_zero_addr_id),
    .use_src_one_id   (use_src_one_id),
    .src_one_addr_id  (src_one_addr_id),
    .load_use         (load_use)
  );

  // A flush kills the ID instruction anyway, so a hazard on it needs no hold.
  assign stall_if_id = stall_ext | (load_use & ~flush_ex);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_ex         <= 1'b0;
      ctrl_ex          <= '0;
      dst_ex           <= '0;
      src_zero_addr_ex <= '0;
      src_one_addr_ex  <= '0;
      src_zero_ex      <= '0;
      src_one_ex       <= '0;
      imm_ex           <= '0;
      pc_ex            <= '0;
      bubble_cnt       <= '0;
      flush_cnt        <= '0;
    end else if (!stall_ext) begin
      // Data fields always follow ID; they only matter when valid_ex is set.
      src_zero_addr_ex <= src_zero_addr_id;
      src_one_addr_ex  <= src_one_addr_id;
      src_zero_ex      <= src_zero_id;
      src_one_ex       <= src_one_id;
      imm_ex           <= imm_id;
      pc_ex            <= pc_id;
      if (flush_ex) begin
        valid_ex  <= 1'b0;
        ctrl_ex   <= '0;
        dst_ex    <= '0;
        flush_cnt <= sat_inc(flush_cnt);
      end else if (load_use) begin
        valid_ex   <= 1'b0;
        ctrl_ex    <= '0;
        dst_ex     <= '0;
        bubble_cnt <= sat_inc(bubble_cnt);
      end else begin
        valid_ex <= valid_id;
        ctrl_ex  <= valid_id ? ctrl_id : '0;
        dst_ex   <= dst_id;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed and random checks of the ID/EX stage register against a
// bench-side reference model feeding an expected-value queue.
module tb_id_ex_stage_reg;
  import mips_pkg::*;

  localparam int EW = 1 + 9 + 5 + 16 + 16;
  localparam int DW = 4 * 32 + 2 * 5;
  localparam ctrl_t LW_C  = '{alu_op: 4'h2, regwrite: 1'b1, memread: 1'b1,
                              memwrite: 1'b0, memtoreg: 1'b1, alusrc: 1'b1};
  localparam ctrl_t ADD_C = '{alu_op: 4'h3, regwrite: 1'b1, memread: 1'b0,
                              memwrite: 1'b0, memtoreg: 1'b0, alusrc: 1'b0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_id;
  logic [4:0]  src_zero_addr_id, src_one_addr_id, dst_id;
  logic        use_src_zero_id, use_src_one_id;
  logic [31:0] src_zero_id, src_one_id, imm_id, pc_id;
  ctrl_t       ctrl_id;
  logic        flush_ex, stall_ext;
  logic        valid_ex;
  ctrl_t       ctrl_ex;
  logic [4:0]  dst_ex, src_zero_addr_ex, src_one_addr_ex;
  logic [31:0] src_zero_ex, src_one_ex, imm_ex, pc_ex;
  logic        stall_if_id;
  logic [15:0] bubble_cnt, flush_cnt;

  int total = 0;
  int bad = 0;

  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] exp_dq[$];
  logic [31:0]   seen[$];

  logic          m_valid = 1'b0;
  ctrl_t         m_ctrl = '0;
  logic [4:0]    m_dst = '0;
  logic [15:0]   m_bcnt = '0;
  logic [15:0]   m_fcnt = '0;
  logic [DW-1:0] m_data = '0;

  always #5 clk = ~clk;

  id_ex_stage_reg dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .valid_id         (valid_id),
    .src_zero_addr_id (src_zero_addr_id),
    .src_one_addr_id  (src_one_addr_id),
    .dst_id           (dst_id),
    .use_src_zero_id  (use_src_zero_id),
    .use_src_one_id   (use_src_one_id),
    .src_zero_id      (src_zero_id),
    .src_one_id       (src_one_id),
    .imm_id           (imm_id),
    .pc_id            (pc_id),
    .ctrl_id          (ctrl_id),
    .flush_ex         (flush_ex),
    .stall_ext        (stall_ext),
    .valid_ex         (valid_ex),
    .ctrl_ex          (ctrl_ex),
    .dst_ex           (dst_ex),
    .src_zero_addr_ex (src_zero_addr_ex),
    .src_one_addr_ex  (src_one_addr_ex),
    .src_zero_ex      (src_zero_ex),
    .src_one_ex       (src_one_ex),
    .imm_ex           (imm_ex),
    .pc_ex            (pc_ex),
    .stall_if_id      (stall_if_id),
    .bubble_cnt       (bubble_cnt),
    .flush_cnt        (flush_cnt)
  );

  // Reference model: evaluated mid-cycle on stable inputs, result queued for the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      logic lu, exp_stall;
      lu = m_valid & m_ctrl.memread & (m_dst != 5'd0) & valid_id &
           ((use_src_zero_id & (src_zero_addr_id == m_dst)) |
            (use_src_one_id & (src_one_addr_id == m_dst)));
      exp_stall = stall_ext | (lu & ~flush_ex);
      total++;
      if (stall_if_id !== exp_stall) begin
        bad++;
        $display("FAIL sb_stall_if_id got=%b exp=%b t=%0t", stall_if_id, exp_stall, $time);
      end
      if (!stall_ext) begin
        m_data = {src_zero_id, src_one_id, imm_id, pc_id, src_zero_addr_id, src_one_addr_id};
        if (flush_ex) begin
          m_valid = 1'b0; m_ctrl = '0; m_dst = '0;
          m_fcnt = (m_fcnt == 16'hFFFF) ? m_fcnt : m_fcnt + 16'd1;
        end else if (lu) begin
          m_valid = 1'b0; m_ctrl = '0; m_dst = '0;
          m_bcnt = (m_bcnt == 16'hFFFF) ? m_bcnt : m_bcnt + 16'd1;
        end else begin
          m_valid = valid_id;
          m_ctrl = valid_id ? ctrl_id : '0;
          m_dst = dst_id;
        end
      end
      exp_q.push_back({m_valid, m_ctrl, m_dst, m_bcnt, m_fcnt});
      exp_dq.push_back(m_data);
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      logic [EW-1:0] e;
      logic [DW-1:0] d, gd;
      e = exp_q.pop_front();
      d = exp_dq.pop_front();
      total++;
      if ({valid_ex, ctrl_ex, dst_ex, bubble_cnt, flush_cnt} !== e) begin
        bad++;
        $display("FAIL sb_ctrl got=%h exp=%h t=%0t",
                 {valid_ex, ctrl_ex, dst_ex, bubble_cnt, flush_cnt}, e, $time);
      end
      if (e[EW-1]) begin
        gd = {src_zero_ex, src_one_ex, imm_ex, pc_ex, src_zero_addr_ex, src_one_addr_ex};
        total++;
        if (gd !== d) begin
          bad++;
          $display("FAIL sb_data got=%h exp=%h t=%0t", gd, d, $time);
        end
      end
    end
  end

  always @(negedge rst_n) begin
    m_valid = 1'b0; m_ctrl = '0; m_dst = '0; m_bcnt = '0; m_fcnt = '0;
    exp_q.delete();
    exp_dq.delete();
  end

  task automatic idle();
    valid_id = 1'b0; ctrl_id = '0; dst_id = '0;
    src_zero_addr_id = '0; src_one_addr_id = '0;
    use_src_zero_id = 1'b0; use_src_one_id = 1'b0;
    src_zero_id = '0; src_one_id = '0; imm_id = '0; pc_id = '0;
    flush_ex = 1'b0; stall_ext = 1'b0;
  endtask

  task automatic drive(input ctrl_t c, input logic [4:0] d, input logic [4:0] a0,
                       input logic u0, input logic [31:0] pc);
    valid_id = 1'b1; ctrl_id = c; dst_id = d;
    src_zero_addr_id = a0; use_src_zero_id = u0;
    src_one_addr_id = 5'd31; use_src_one_id = 1'b0;
    src_zero_id = pc ^ 32'hA5A5_0000; src_one_id = ~pc; imm_id = pc + 32'd4; pc_id = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Holds the instruction in ID until the stage stops asking IF/ID to hold.
  task automatic issue(input ctrl_t c, input logic [4:0] d, input logic [4:0] a0,
                       input logic u0, input logic [31:0] pc);
    int n;
    logic s;
    drive(c, d, a0, u0, pc);
    n = 0;
    do begin
      #1 s = stall_if_id;
      @(posedge clk);
      #1;
      if (valid_ex) seen.push_back(pc_ex);
      #1;
      n++;
    end while (s && n < 8);
    if (s) begin
      total++; bad++;
      $display("FAIL issue_timeout pc=%h cycles=%0d", pc, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #3;
    total++;
    if ({valid_ex, ctrl_ex, dst_ex, src_zero_ex, src_one_ex, imm_ex, pc_ex,
         src_zero_addr_ex, src_one_addr_ex, bubble_cnt, flush_cnt, stall_if_id} !== '0) begin
      bad++;
      $display("FAIL reset_state got valid=%b pc=%h bcnt=%h fcnt=%h stall=%b exp all zero",
               valid_ex, pc_ex, bubble_cnt, flush_cnt, stall_if_id);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    drive(LW_C, 5'd5, 5'd1, 1'b1, 32'h100);
    tick();
    drive(ADD_C, 5'd7, 5'd5, 1'b1, 32'h104);
    #1;
    total++;
    if (stall_if_id !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", stall_if_id); end
    tick();
    total++;
    if ({valid_ex, bubble_cnt, stall_if_id} !== {1'b0, 16'd1, 1'b0}) begin
      bad++;
      $display("FAIL lu_bubble got valid=%b bcnt=%0d stall=%b exp 0/1/0", valid_ex, bubble_cnt, stall_if_id);
    end
    tick();
    total++;
    if ({valid_ex, pc_ex, dst_ex} !== {1'b1, 32'h104, 5'd7}) begin
      bad++;
      $display("FAIL lu_add_enters got valid=%b pc=%h dst=%0d exp 1/104/7", valid_ex, pc_ex, dst_ex);
    end
    idle();
    tick();
  endtask

  task automatic test_reg_zero();
    do_reset();
    drive(LW_C, 5'd0, 5'd1, 1'b1, 32'h200);
    tick();
    drive(ADD_C, 5'd3, 5'd0, 1'b1, 32'h204);
    #1;
    total++;
    if (stall_if_id !== 1'b0) begin bad++; $display("FAIL r0_stall got=%b exp=0", stall_if_id); end
    tick();
    total++;
    if ({valid_ex, pc_ex, bubble_cnt} !== {1'b1, 32'h204, 16'd0}) begin
      bad++;
      $display("FAIL r0_advance got valid=%b pc=%h bcnt=%0d exp 1/204/0", valid_ex, pc_ex, bubble_cnt);
    end
    idle();
    tick();
  endtask

  task automatic test_flush_over_load_use();
    do_reset();
    drive(LW_C, 5'd5, 5'd1, 1'b1, 32'h300);
    tick();
    drive(ADD_C, 5'd7, 5'd5, 1'b1, 32'h304);
    flush_ex = 1'b1;
    #1;
    total++;
    if (stall_if_id !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stall_if_id); end
    tick();
    total++;
    if ({valid_ex, ctrl_ex, flush_cnt, bubble_cnt} !== {1'b0, 9'd0, 16'd1, 16'd0}) begin
      bad++;
      $display("FAIL flush_result got valid=%b ctrl=%h fcnt=%0d bcnt=%0d exp 0/0/1/0",
               valid_ex, ctrl_ex, flush_cnt, bubble_cnt);
    end
    idle();
    tick();
  endtask

  task automatic test_stall_ext();
    do_reset();
    drive(LW_C, 5'd5, 5'd1, 1'b1, 32'h400);
    tick();
    drive(ADD_C, 5'd7, 5'd5, 1'b1, 32'h404);
    stall_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({valid_ex, pc_ex, dst_ex, bubble_cnt, stall_if_id} !== {1'b1, 32'h400, 5'd5, 16'd0, 1'b1}) begin
        bad++;
        $display("FAIL stall_frozen c%0d got valid=%b pc=%h dst=%0d bcnt=%0d stall=%b exp 1/400/5/0/1",
                 i, valid_ex, pc_ex, dst_ex, bubble_cnt, stall_if_id);
      end
    end
    stall_ext = 1'b0;
    tick();
    total++;
    if ({valid_ex, bubble_cnt} !== {1'b0, 16'd1}) begin
      bad++;
      $display("FAIL stall_release got valid=%b bcnt=%0d exp 0/1", valid_ex, bubble_cnt);
    end
    tick();
    total++;
    if ({valid_ex, pc_ex} !== {1'b1, 32'h404}) begin
      bad++;
      $display("FAIL stall_add_enters got valid=%b pc=%h exp 1/404", valid_ex, pc_ex);
    end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    seen.delete();
    issue(LW_C, 5'd5, 5'd1, 1'b1, 32'h500);
    issue(LW_C, 5'd6, 5'd5, 1'b1, 32'h504);
    issue(ADD_C, 5'd7, 5'd6, 1'b1, 32'h508);
    idle();
    tick();
    total++;
    if (seen.size() != 3 || seen[0] !== 32'h500 || seen[1] !== 32'h504 || seen[2] !== 32'h508) begin
      bad++;
      $display("FAIL b2b_order got n=%0d first=%h exp n=3 500,504,508", seen.size(),
               (seen.size() > 0) ? seen[0] : 32'h0);
    end
    total++;
    if (bubble_cnt !== 16'd2) begin bad++; $display("FAIL b2b_bubbles got=%0d exp=2", bubble_cnt); end
  endtask

  task automatic test_saturate();
    do_reset();
    force dut.bubble_cnt = 16'hFFFE;
    m_bcnt = 16'hFFFE;
    #1 release dut.bubble_cnt;
    for (int i = 0; i < 3; i++) begin
      issue(LW_C, 5'd5, 5'd1, 1'b1, 32'h600 + 32'(i * 8));
      issue(ADD_C, 5'd7, 5'd5, 1'b1, 32'h604 + 32'(i * 8));
    end
    idle();
    tick();
    total++;
    if (bubble_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_bubble got=%h exp=ffff", bubble_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(LW_C, 5'd5, 5'd1, 1'b1, 32'h700);
    tick();
    drive(ADD_C, 5'd7, 5'd5, 1'b1, 32'h704);
    #1;
    total++;
    if (stall_if_id !== 1'b1) begin bad++; $display("FAIL arst_pre_stall got=%b exp=1", stall_if_id); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({valid_ex, ctrl_ex, dst_ex, pc_ex, imm_ex, bubble_cnt, flush_cnt, stall_if_id} !== '0) begin
      bad++;
      $display("FAIL arst_clear got valid=%b ctrl=%h dst=%0d pc=%h stall=%b exp all zero",
               valid_ex, ctrl_ex, dst_ex, pc_ex, stall_if_id);
    end
    tick();
    rst_n = 1'b1;
    total++;
    if (valid_ex !== 1'b0) begin bad++; $display("FAIL arst_resume_empty got=%b exp=0", valid_ex); end
    tick();
    total++;
    if ({valid_ex, pc_ex} !== {1'b1, 32'h704}) begin
      bad++;
      $display("FAIL arst_resume got valid=%b pc=%h exp 1/704", valid_ex, pc_ex);
    end
    idle();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      valid_id = 1'($urandom_range(0, 1));
      ctrl_id = ctrl_t'($urandom_range(0, 511));
      dst_id = 5'($urandom_range(0, 3));
      src_zero_addr_id = 5'($urandom_range(0, 3));
      src_one_addr_id = 5'($urandom_range(0, 3));
      use_src_zero_id = 1'($urandom_range(0, 1));
      use_src_one_id = 1'($urandom_range(0, 1));
      src_zero_id = $urandom; src_one_id = $urandom; imm_id = $urandom; pc_id = $urandom;
      flush_ex = ($urandom_range(0, 7) == 0);
      stall_ext = ($urandom_range(0, 7) == 0);
      tick();
    end
    idle();
    tick();
    tick();
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_reg_zero();
    test_flush_over_load_use();
    test_stall_ext();
    test_back_to_back();
    test_saturate();
    test_async_reset();
    test_random();
    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
